// File: rtl/raster_scan_gen.sv
// Raster-order pixel coordinate/address generator driven by the run-control FSM state.
// Emits x/y/linear address with valid/ready handshake, frame flags and a completed-frame count.
module raster_scan_gen #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 48,
  parameter int X_W    = 8,
  parameter int Y_W    = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        fsm_state,
  input  logic              pix_ready,
  output logic              pix_valid,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  state_t              state_r, state_s;
  logic [X_W-1:0]      x_r, x_s;
  logic [Y_W-1:0]      y_r, y_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic                mode_r, mode_s;
  logic                done_r, done_s;
  logic [7:0]          cnt_r, cnt_s;
  logic                run_s;
  logic                last_s;

  assign run_s  = (fsm_state == 2'b01) || (fsm_state == 2'b10);
  assign last_s = (x_r == X_LAST) && (y_r == Y_LAST);

  // Next-state, counter advance and frame accounting
  always_comb begin
    state_s = state_r;
    x_s     = x_r;
    y_s     = y_r;
    addr_s  = addr_r;
    mode_s  = mode_r;
    done_s  = 1'b0;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (run_s) begin
          state_s = SCAN;
          mode_s  = (fsm_state == 2'b10);
          x_s     = '0;
          y_s     = '0;
          addr_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        // Abort wins over a coincident last-pixel transfer
        if (!run_s) begin
          state_s = IDLE;
          x_s     = '0;
          y_s     = '0;
          addr_s  = '0;
        end else if (pix_ready) begin
          if (last_s) begin
            done_s = 1'b1;
            cnt_s  = cnt_r + 8'd1;
            x_s    = '0;
            y_s    = '0;
            addr_s = '0;
            if (mode_r && (fsm_state == 2'b10)) begin
              state_s = SCAN;
            end else begin
              state_s = DONE;
            end
          end else if (x_r == X_LAST) begin
            x_s    = '0;
            y_s    = y_r + Y_W'(1);
            addr_s = addr_r + ADDR_W'(1);
          end else begin
            x_s    = x_r + X_W'(1);
            addr_s = addr_r + ADDR_W'(1);
          end
        end else begin
          state_s = SCAN;
        end
      end
      DONE: begin
        if (!run_s) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        x_s     = '0;
        y_s     = '0;
        addr_s  = '0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      x_r     <= '0;
      y_r     <= '0;
      addr_r  <= '0;
      mode_r  <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      x_r     <= x_s;
      y_r     <= y_s;
      addr_r  <= addr_s;
      mode_r  <= mode_s;
      done_r  <= done_s;
      cnt_r   <= cnt_s;
    end
  end

  assign pix_valid  = (state_r == SCAN);
  assign busy       = (state_r == SCAN);
  assign pix_x      = x_r;
  assign pix_y      = y_r;
  assign pix_addr   = addr_r;
  assign sof        = pix_valid && (x_r == X_W'(0)) && (y_r == Y_W'(0));
  assign eol        = pix_valid && (x_r == X_LAST);
  assign eof        = pix_valid && last_s;
  assign frame_done = done_r;
  assign frame_cnt  = cnt_r;

endmodule

// File: tb/tb_raster_scan_gen.sv
// Bench for raster_scan_gen: linear-pixel-index reference model compared every cycle,
// directed scenarios with literal expectations, then randomized state/ready/reset stimulus.
module tb_raster_scan_gen;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int X_W    = 8;
  localparam int Y_W    = 8;
  localparam int ADDR_W = 12;
  localparam int NPIX   = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        fsm_state;
  logic              pix_ready;
  logic              pix_valid;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic [ADDR_W-1:0] pix_addr;
  logic              sof, eol, eof, frame_done, busy;
  logic [7:0]        frame_cnt;

  raster_scan_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .fsm_state(fsm_state), .pix_ready(pix_ready),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_addr(pix_addr),
    .sof(sof), .eol(eol), .eof(eof), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase 0 idle / 1 scanning / 2 finished, p = linear pixel index
  int ph = 0;
  int p = 0;
  int cnt = 0;
  bit cont = 1'b0;
  bit fd = 1'b0;

  always @(posedge clk) begin
    bit run;
    run = (fsm_state == 2'b01) || (fsm_state == 2'b10);
    if (reset) begin
      ph = 0; p = 0; cnt = 0; cont = 1'b0; fd = 1'b0;
    end else begin
      fd = 1'b0;
      if (ph == 0) begin
        if (run) begin
          ph = 1; p = 0; cont = (fsm_state == 2'b10);
        end
      end else if (ph == 1) begin
        if (!run) begin
          ph = 0; p = 0;
        end else if (pix_ready) begin
          if (p == NPIX - 1) begin
            fd = 1'b1;
            cnt = (cnt + 1) % 256;
            p = 0;
            if (!(cont && fsm_state == 2'b10)) ph = 2;
          end else begin
            p = p + 1;
          end
        end
      end else begin
        if (!run) ph = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  int valid_seen = 0;
  int fd_seen = 0;

  task automatic check_all();
    bit v;
    v = (ph == 1);
    chk("pix_valid", 32'(pix_valid), 32'(v));
    chk("busy", 32'(busy), 32'(v));
    chk("pix_x", 32'(pix_x), v ? 32'(p % IMG_W) : 32'd0);
    chk("pix_y", 32'(pix_y), v ? 32'(p / IMG_W) : 32'd0);
    chk("pix_addr", 32'(pix_addr), v ? 32'(p) : 32'd0);
    chk("sof", 32'(sof), 32'(v && p == 0));
    chk("eol", 32'(eol), 32'(v && (p % IMG_W) == IMG_W - 1));
    chk("eof", 32'(eof), 32'(v && p == NPIX - 1));
    chk("frame_done", 32'(frame_done), 32'(fd));
    chk("frame_cnt", 32'(frame_cnt), 32'(cnt));
    if (pix_valid === 1'b1) valid_seen++;
    if (frame_done === 1'b1) fd_seen++;
  endtask

  task automatic cyc(input logic [1:0] st, input logic rdy, input logic rst);
    fsm_state = st;
    pix_ready = rdy;
    reset = rst;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    fsm_state = 2'b00;
    pix_ready = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    cyc(2'b01, 1'b1, 1'b1);
    check_all();
    chk("reset_valid", 32'(pix_valid), 32'd0);
    chk("reset_cnt", 32'(frame_cnt), 32'd0);

    // Single frame, no backpressure
    cyc(2'b01, 1'b1, 1'b0);
    chk("t1_first_valid", 32'(pix_valid), 32'd1);
    chk("t1_first_sof", 32'(sof), 32'd1);
    for (int k = 1; k < NPIX; k++) begin
      cyc(2'b01, 1'b1, 1'b0);
      chk("t1_addr_seq", 32'(pix_addr), 32'(k));
    end
    chk("t1_eof_at_11", 32'(eof), 32'd1);
    cyc(2'b01, 1'b1, 1'b0);
    chk("t1_frame_done", 32'(frame_done), 32'd1);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_valid_low", 32'(pix_valid), 32'd0);
    for (int k = 0; k < 4; k++) cyc(2'b01, 1'b1, 1'b0);
    chk("t1_stays_done", 32'(pix_valid), 32'd0);

    // Continuous mode for 30 cycles
    cyc(2'b00, 1'b1, 1'b0);
    fd_seen = 0;
    for (int k = 0; k < 30; k++) cyc(2'b10, 1'b1, 1'b0);
    chk("t2_fd_pulses", 32'(fd_seen), 32'd2);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd3);

    // Backpressure at addr 5
    cyc(2'b00, 1'b1, 1'b0);
    valid_seen = 0;
    cyc(2'b01, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) cyc(2'b01, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(2'b01, 1'b0, 1'b0);
      chk("t3_hold_addr", 32'(pix_addr), 32'd5);
      chk("t3_hold_x", 32'(pix_x), 32'd1);
      chk("t3_hold_y", 32'(pix_y), 32'd1);
    end
    for (int k = 0; k < 10; k++) cyc(2'b01, 1'b1, 1'b0);
    chk("t3_valid_cycles", 32'(valid_seen), 32'd15);
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd4);

    // Abort at addr 6
    cyc(2'b00, 1'b1, 1'b0);
    cyc(2'b01, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) cyc(2'b01, 1'b1, 1'b0);
    chk("t4_at_addr6", 32'(pix_addr), 32'd6);
    cyc(2'b00, 1'b1, 1'b0);
    chk("t4_abort_valid", 32'(pix_valid), 32'd0);
    chk("t4_abort_nodone", 32'(frame_done), 32'd0);
    chk("t4_abort_cnt", 32'(frame_cnt), 32'd4);
    cyc(2'b01, 1'b1, 1'b0);
    chk("t4_restart_addr", 32'(pix_addr), 32'd0);
    chk("t4_restart_sof", 32'(sof), 32'd1);

    // Continuous frame, switched to single mid-frame
    cyc(2'b00, 1'b1, 1'b0);
    cyc(2'b10, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc(2'b10, 1'b1, 1'b0);
    fd_seen = 0;
    for (int k = 0; k < 20; k++) cyc(2'b01, 1'b1, 1'b0);
    chk("t5_one_done", 32'(fd_seen), 32'd1);
    chk("t5_no_wrap", 32'(pix_valid), 32'd0);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd5);

    // Reset mid-frame at addr 7
    cyc(2'b00, 1'b1, 1'b0);
    cyc(2'b10, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) cyc(2'b10, 1'b1, 1'b0);
    chk("t6_at_addr7", 32'(pix_addr), 32'd7);
    cyc(2'b10, 1'b1, 1'b1);
    chk("t6_rst_valid", 32'(pix_valid), 32'd0);
    chk("t6_rst_addr", 32'(pix_addr), 32'd0);
    chk("t6_rst_cnt", 32'(frame_cnt), 32'd0);
    cyc(2'b10, 1'b1, 1'b0);
    chk("t6_restart_valid", 32'(pix_valid), 32'd1);
    chk("t6_restart_addr", 32'(pix_addr), 32'd0);

    // Randomized run: sticky state changes, random ready, rare reset
    begin
      logic [1:0] st;
      st = 2'b10;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 24) == 0) st = 2'($urandom_range(0, 3));
        cyc(st, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 299) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/raster_scan_gen.md
Name: raster_scan_gen

Overview:
- Sits directly downstream of the run-control FSM (`fsm`): consumes its 2-bit `state` output.
- While the FSM is in a run state, generates raster-order pixel coordinates and linear frame-buffer addresses for the image-processing datapath.
- Handshake to the datapath is valid/ready.
- Reports frame boundaries and a completed-frame count back to control.

Parameters:
- IMG_W, 64, pixels per line (>=2)
- IMG_H, 48, lines per frame (>=2)
- X_W, 8, width of x coordinate (2^X_W >= IMG_W)
- Y_W, 8, width of y coordinate (2^Y_W >= IMG_H)
- ADDR_W, 12, width of linear address (2^ADDR_W >= IMG_W*IMG_H)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- fsm_state  in  2  run-control state: 2'b00 IDLE, 2'b01 RUN_SINGLE (mode 0), 2'b10 RUN_CONT (mode 1), 2'b11 reserved (treated as IDLE)
- pix_ready  in  1  datapath accepts current pixel
- pix_valid  out  1  x/y/addr/flags valid
- pix_x  out  X_W  column, 0..IMG_W-1
- pix_y  out  Y_W  line, 0..IMG_H-1
- pix_addr  out  ADDR_W  pix_y*IMG_W+pix_x
- sof  out  1  qualifies pixel (0,0)
- eol  out  1  qualifies pixel x=IMG_W-1
- eof  out  1  qualifies last pixel (IMG_W-1, IMG_H-1)
- frame_done  out  1  one-cycle pulse after last pixel accepted
- frame_cnt  out  8  completed frames, wraps 255->0
- busy  out  1  high in SCAN

Behaviour:
- Reset (sync, active-high): all outputs 0, internal state IDLE. Reset overrides every other input on the same edge.
- Internal states: IDLE, SCAN, DONE.
- Transfer rule: a pixel transfers on an edge where pix_valid && pix_ready.
- Hold rule: while pix_valid && !pix_ready, pix_x, pix_y, pix_addr, sof, eol and eof are held stable.

- IDLE:
  - On an edge sampling fsm_state in {01,10}: go to SCAN with x=0, y=0, addr=0.
  - pix_valid=1 and sof=1 appear the cycle after the run state is first sampled (1-cycle latency).
- SCAN, on each transfer:
  - x<IMG_W-1: x+1, addr+1.
  - x==IMG_W-1 and y<IMG_H-1: x=0, y+1, addr+1.
  - Last pixel of a RUN_SINGLE frame: go to DONE.
  - Last pixel of a RUN_CONT frame: x=0, y=0, addr=0, remain in SCAN. Next pixel is presented the following cycle with sof=1; no bubble.
  - Last pixel, either mode: frame_done=1 on the next cycle; frame_cnt increments in the same cycle.
- Mode is latched at IDLE->SCAN:
  - fsm_state switching 01<->10 mid-frame changes nothing until the next entry from IDLE.
  - Exception: in a RUN_CONT frame, if fsm_state==01 is sampled on the last-pixel transfer, go to DONE instead of wrapping.
- Abort: fsm_state sampled as 00 or 11 in SCAN (with or without a transfer that edge):
  - Go to IDLE; pix_valid=0 next cycle; x/y/addr cleared.
  - No frame_done pulse; frame_cnt unchanged.
  - Abort takes priority over a simultaneous last-pixel transfer.
- DONE:
  - pix_valid=0, busy=0.
  - Remains until fsm_state is sampled as 00 or 11, then IDLE. A held run state does not retrigger.
- Flags:
  - Combinational decodes of the registered x/y, gated by pix_valid.
  - When IMG_W==... any degenerate case is excluded by the parameter limits.
- Address: an incremental counter; no multiplier. Must equal y*IMG_W+x at all times.
- frame_cnt: cleared only by reset.

Test Plan:
- IMG_W=4, IMG_H=3, pix_ready=1, fsm_state 00->01:
  - pix_valid rises 1 cycle later with sof.
  - addr 0..11 in 12 consecutive cycles; eol at addr 3, 7, 11; eof at addr 11.
  - frame_done pulse at the cycle after addr 11; frame_cnt=1; pix_valid=0; stays in DONE while state=01.
- Same setup, fsm_state=10 held for 30 cycles:
  - addr wraps 11->0 with sof, no gap.
  - frame_done pulses each 12 cycles; frame_cnt=2 after 24 transfers.
- Backpressure: pix_ready low for 3 cycles at addr 5, otherwise high:
  - addr 5, x=1, y=1 held stable for those 3 cycles.
  - Frame completes in 15 cycles; no pixel skipped or repeated.
- Abort: fsm_state=00 at addr 6 in RUN_SINGLE:
  - pix_valid=0 next cycle; no frame_done; frame_cnt unchanged.
  - Re-entering 01 restarts at addr 0 with sof.
- RUN_CONT, fsm_state switched to 01 at addr 4:
  - The frame continues to addr 11.
  - frame_done fires; enters DONE, no wrap.
- Reset asserted mid-frame at addr 7:
  - All outputs 0 next cycle, including frame_cnt.
  - With fsm_state held 10 after reset release, scan restarts at addr 0.
